e203_subsys_clkdiv_ctrl: RTL

Sequencer that sits directly upstream of the subsystem PLL clock divider and drives its `divby1`/`div` controls. It accepts a new divide setting over a valid/ready handshake and applies it safely: it holds the divided clock off, drains any in-flight output pulse, updates the divider controls, waits a settle window, then releases the clock and signals completion. This keeps software- or PMU-initiated rate changes free of runt pulses on the divided clock.

---
 rtl/e203_subsys_clkdiv_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/e203_subsys_clkdiv_ctrl.sv
// e203_subsys_clkdiv_ctrl
// Sequencer in front of the subsystem PLL clock divider. A new divide
// setting arrives over a valid/ready handshake. The block then gates the
// divided clock off, drains any in-flight divider output pulse, updates
// the divider controls, waits a settle window and releases the clock again.
// This keeps rate changes from producing runt pulses on the divided clock.
//
// Ports
//   clk         PLL source clock (same clock as the divider)
//   rst         synchronous, active-high reset
//   cfg_valid   new-setting request
//   cfg_ready   request accepted when cfg_valid & cfg_ready (IDLE decode)
//   cfg_divby1  requested bypass; cfg_div is then not compared
//   cfg_div     requested divide code, period = 2*(cfg_div+1) source cycles
//   divby1      registered divider bypass control
//   div         registered divider code
//   clk_hold    registered; 1 forces the downstream clock gate enable low
//   busy        sequence in progress (state != IDLE)
//   done        one-cycle pulse when a request completes
module e203_subsys_clkdiv_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [5:0]  DIV_RST       = 6'd0,
  parameter logic        DIVBY1_RST    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic       cfg_divby1,
  input  logic [5:0] cfg_div,
  output logic       divby1,
  output logic [5:0] div,
  output logic       clk_hold,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    LOAD   = 2'd2,
    SETTLE = 2'd3
  } state_e;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req_divby1_q, req_divby1_d;
  logic [5:0] req_div_q, req_div_d;
  logic       divby1_q, divby1_d;
  logic [5:0] div_q, div_d;
  logic       clk_hold_q, clk_hold_d;
  logic       done_q, done_d;

  logic       accept;
  logic       req_match;
  logic [7:0] drain_init;

  assign accept = cfg_valid && (state_q == IDLE);

  // A bypass request matches whenever bypass is already active; div is
  // irrelevant to the divided clock in that case.
  assign req_match = (cfg_divby1 == divby1_q) &&
                     (cfg_divby1 || (cfg_div == div_q));

  // One full output period minus one, 2*(div+1)-1 = {div,1}. In bypass there
  // is no divider pulse in flight, so a single drain cycle is enough.
  assign drain_init = divby1_q ? 8'd0 : {1'b0, div_q, 1'b1};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !req_match) state_d = DRAIN;
      DRAIN:   if (cnt_q == 8'd0)        state_d = LOAD;
      LOAD:                              state_d = SETTLE;
      SETTLE:  if (cnt_q == 8'd0)        state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cfg_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
  end

  // Counter, captured request and registered controls
  always_comb begin
    cnt_d        = cnt_q;
    req_divby1_d = req_divby1_q;
    req_div_d    = req_div_q;
    divby1_d     = divby1_q;
    div_d        = div_q;
    clk_hold_d   = clk_hold_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_divby1_d = cfg_divby1;
          req_div_d    = cfg_div;
          if (req_match) begin
            done_d = 1'b1;
          end else begin
            clk_hold_d = 1'b1;
            cnt_d      = drain_init;
          end
        end
      end
      DRAIN: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
      end
      LOAD: begin
        divby1_d = req_divby1_q;
        div_d    = req_div_q;
        cnt_d    = SETTLE_INIT;
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          clk_hold_d = 1'b0;
          done_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        clk_hold_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divby1_q   <= DIVBY1_RST;
      div_q      <= DIV_RST;
      clk_hold_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      divby1_q   <= divby1_d;
      div_q      <= div_d;
      clk_hold_q <= clk_hold_d;
      done_q     <= done_d;
    end
  end

  // Pure datapath: only meaningful after an accept, so no reset needed.
  always_ff @(posedge clk) begin
    cnt_q        <= cnt_d;
    req_divby1_q <= req_divby1_d;
    req_div_q    <= req_div_d;
  end

  assign divby1   = divby1_q;
  assign div      = div_q;
  assign clk_hold = clk_hold_q;
  assign done     = done_q;

endmodule
